// File: rtl/mips_multicycle_ctrl_pkg.sv
// mips_ctrl_pkg: ALUOp codes, opcode/funct values, mux select codes, FSM states and the decode dispatch helper
package mips_ctrl_pkg;
  localparam logic [2:0] ALU_AND = 3'd0, ALU_OR = 3'd1, ALU_ADD = 3'd2, ALU_SUB = 3'd3,
                         ALU_XOR = 3'd4, ALU_SLTU = 3'd5, ALU_SLT = 3'd6;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
                         FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  localparam logic [1:0] SRCB_B = 2'd0, SRCB_4 = 2'd1, SRCB_IMM = 2'd2, SRCB_IMM_SH = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RWB, IEXEC, IWB, BRANCH, JUMP, ILLEGAL, HALT
  } state_t;
  function automatic state_t decode_target(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW: return MEMADR;
      OP_RTYPE: return RTEXEC;
      OP_BEQ, OP_BNE: return BRANCH;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU: return IEXEC;
      OP_J: return JUMP;
      default: return ILLEGAL;
    endcase
  endfunction
endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: control bus; master = controller (opcode/funct/zero/mem_ready in, datapath/memory controls out), slave = datapath side
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode, funct;
  logic zero, mem_ready;
  logic [2:0] alu_op;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic ext_zero;
  logic [1:0] pc_src;
  logic pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal, halted;
  modport master (
    input opcode, funct, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, iord, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, illegal, halted
  );
  modport slave (
    output opcode, funct, zero, mem_ready,
    input alu_op, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, iord, mem_read, mem_write,
          ir_write, reg_dst, mem_to_reg, reg_write, illegal, halted
  );
endinterface

// File: rtl/mips_multicycle_ctrl_alu_op_decode.sv
// alu_op_decode: state/opcode/funct in; alu_op, ext_zero and funct-valid flag out
module alu_op_decode import mips_ctrl_pkg::*; (
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       ext_zero,
  output logic       valid
);
  logic [2:0] fn_op, im_op;
  logic fn_ok;
  always_comb begin
    fn_op = ALU_ADD;
    fn_ok = 1'b1;
    case (funct)
      FN_ADD, FN_ADDU: fn_op = ALU_ADD;
      FN_SUB, FN_SUBU: fn_op = ALU_SUB;
      FN_AND: fn_op = ALU_AND;
      FN_OR: fn_op = ALU_OR;
      FN_XOR: fn_op = ALU_XOR;
      FN_SLT: fn_op = ALU_SLT;
      FN_SLTU: fn_op = ALU_SLTU;
      default: fn_ok = 1'b0;
    endcase
    im_op = opcode == OP_ANDI ? ALU_AND : opcode == OP_ORI ? ALU_OR : opcode == OP_XORI ? ALU_XOR :
            opcode == OP_SLTI ? ALU_SLT : opcode == OP_SLTIU ? ALU_SLTU : ALU_ADD;
    alu_op = state == RTEXEC ? fn_op : state == IEXEC ? im_op : state == BRANCH ? ALU_SUB : ALU_ADD;
    ext_zero = (state inside {IEXEC, IWB}) && (opcode inside {OP_ANDI, OP_ORI, OP_XORI});
    valid = state != RTEXEC || fn_ok;
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multicycle MIPS control FSM; clk, rst_n (async active-low), bus (mips_multicycle_ctrl_if.master)
module mips_multicycle_ctrl import mips_ctrl_pkg::*; #(
  parameter bit RESET_ON_ILLEGAL = 1'b0
) (
  input logic clk,
  input logic rst_n,
  mips_multicycle_ctrl_if.master bus
);
  state_t state_q, state_d;
  logic rdy, valid, br_take, ext_zero;
  logic [2:0] alu_op;
  assign rdy = bus.mem_ready & rst_n;
  assign br_take = bus.opcode == OP_BNE ? ~bus.zero : bus.zero;
  alu_op_decode u_alu_op_decode (
    .state(state_q), .opcode(bus.opcode), .funct(bus.funct),
    .alu_op(alu_op), .ext_zero(ext_zero), .valid(valid)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: state_d = rdy ? DECODE : FETCH;
      DECODE: state_d = decode_target(bus.opcode);
      MEMADR: state_d = bus.opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD: state_d = rdy ? MEMWB : MEMRD;
      MEMWR: state_d = rdy ? FETCH : MEMWR;
      RTEXEC: state_d = valid ? RWB : ILLEGAL;
      IEXEC: state_d = IWB;
      ILLEGAL: state_d = RESET_ON_ILLEGAL ? HALT : FETCH;
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= FETCH;
    else state_q <= state_d;
  assign bus.alu_op = alu_op;
  assign bus.ext_zero = ext_zero;
  assign bus.alu_src_a = state_q inside {MEMADR, RTEXEC, IEXEC, BRANCH};
  assign bus.alu_src_b = (state_q == FETCH && rst_n) ? SRCB_4 : state_q == DECODE ? SRCB_IMM_SH :
                         (state_q inside {MEMADR, IEXEC}) ? SRCB_IMM : SRCB_B;
  assign bus.pc_src = state_q == BRANCH ? PC_ALUOUT : state_q == JUMP ? PC_JUMP : PC_ALU;
  assign bus.pc_en = (state_q == FETCH && rdy) || state_q == JUMP || (state_q == BRANCH && br_take);
  assign bus.iord = state_q inside {MEMRD, MEMWR};
  assign bus.mem_read = state_q inside {FETCH, MEMRD};
  assign bus.mem_write = state_q == MEMWR;
  assign bus.ir_write = state_q == FETCH && rdy;
  assign bus.reg_dst = state_q == RWB;
  assign bus.mem_to_reg = state_q == MEMWB;
  assign bus.reg_write = state_q inside {MEMWB, RWB, IWB};
  assign bus.illegal = state_q == ILLEGAL;
  assign bus.halted = state_q == HALT;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: table-driven and randomized checks of the multicycle MIPS controller
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;
  typedef struct {
    logic [5:0] op, fn;
    logic z;
    int wf, wd, cyc, aop;
    logic ez, tk, rw, ill;
  } vec_t;
  localparam logic [18:0] RST = {3'd2, 8'd0, 1'b1, 7'd0};
  localparam logic [5:0] FSIG = 6'b100100;
  logic clk = 1'b0, rst_n = 1'b0, rst_b = 1'b1, rst_nb;
  logic hb = 1'b0;
  int n_vec = 0, n_bad = 0;
  mips_multicycle_ctrl_if ifa ();
  mips_multicycle_ctrl_if ifb ();
  assign rst_nb = rst_n & rst_b;
  assign ifb.opcode = ifa.opcode;
  assign ifb.funct = ifa.funct;
  assign ifb.zero = ifa.zero;
  assign ifb.mem_ready = ifa.mem_ready;
  mips_multicycle_ctrl #(.RESET_ON_ILLEGAL(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
  mips_multicycle_ctrl #(.RESET_ON_ILLEGAL(1'b1)) dut_b (.clk(clk), .rst_n(rst_nb), .bus(ifb.master));
  always #5 clk = ~clk;
  function automatic logic [18:0] outs_a();
    return {ifa.alu_op, ifa.alu_src_a, ifa.alu_src_b, ifa.ext_zero, ifa.pc_src, ifa.pc_en, ifa.iord,
            ifa.mem_read, ifa.mem_write, ifa.ir_write, ifa.reg_dst, ifa.mem_to_reg, ifa.reg_write,
            ifa.illegal, ifa.halted};
  endfunction
  function automatic logic [5:0] fsig_a();
    return {ifa.mem_read, ifa.iord, ifa.alu_src_b, ifa.mem_write, ifa.halted};
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [5:0] op, fn, input logic z, input int wf, wd, cyc, aop,
                              input logic ez, tk, rw, ill);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.wf = wf; v.wd = wd; v.cyc = cyc; v.aop = aop;
    v.ez = ez; v.tk = tk; v.rw = rw; v.ill = ill;
    return v;
  endfunction
  function automatic vec_t model(input logic [5:0] op, fn, input logic z, input int wf, wd);
    int base = 4, a = 7, dw = 0;
    logic ez = 0, tk = 0, rw = 0, ill = 0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20, 6'h21: a = 2;
          6'h22, 6'h23: a = 3;
          6'h24: a = 0;
          6'h25: a = 1;
          6'h26: a = 4;
          6'h2A: a = 6;
          6'h2B: a = 5;
          default: ill = 1;
        endcase
        rw = !ill;
      end
      6'h23: begin base = 5; a = 2; rw = 1; dw = wd; end
      6'h2B: begin a = 2; dw = wd; end
      6'h04: begin base = 3; a = 3; tk = z; end
      6'h05: begin base = 3; a = 3; tk = !z; end
      6'h02: begin base = 3; tk = 1; end
      6'h08, 6'h09: begin a = 2; rw = 1; end
      6'h0A: begin a = 6; rw = 1; end
      6'h0B: begin a = 5; rw = 1; end
      6'h0C: begin a = 0; rw = 1; ez = 1; end
      6'h0D: begin a = 1; rw = 1; ez = 1; end
      6'h0E: begin a = 4; rw = 1; ez = 1; end
      default: begin base = 3; ill = 1; end
    endcase
    return mk(op, fn, z, wf, dw, base + wf + dw, a, ez, tk, rw, ill);
  endfunction
  task automatic run(input vec_t v, input string tag);
    int q[$];
    int cnt = 0, n_ir = 0, n_rw = 0, n_mw = 0, n_dr = 0, n_pc = 0, n_ill = 0, xop = 7, psrc = 0;
    bit busy = 0, req;
    logic ez = 0, rd = 0, m2r = 0;
    ifa.opcode = v.op;
    ifa.funct = v.fn;
    ifa.zero = v.z;
    q.push_back(v.wf);
    q.push_back(v.wd);
    for (int c = 0; c < v.cyc; c++) begin
      req = ifa.mem_read | ifa.mem_write;
      if (req && !busy) begin
        busy = 1;
        cnt = q.size() > 0 ? q.pop_front() : 0;
      end
      ifa.mem_ready = req ? (cnt == 0) : 1'($urandom_range(0, 1));
      #1;
      if (ifa.ir_write) n_ir++;
      if (ifa.reg_write) begin n_rw++; rd = ifa.reg_dst; m2r = ifa.mem_to_reg; end
      if (ifa.mem_write) n_mw++;
      if (ifa.mem_read && ifa.iord) n_dr++;
      if (ifa.pc_en) n_pc++;
      if (ifa.pc_en && !ifa.ir_write) psrc = ifa.pc_src;
      if (ifa.illegal) n_ill++;
      if (ifa.alu_src_a) xop = ifa.alu_op;
      ez |= ifa.ext_zero;
      if (req) begin
        if (ifa.mem_ready) busy = 0;
        else cnt--;
      end
      @(posedge clk);
      #1;
    end
    ifa.mem_ready = 1'b0;
    #1;
    if (v.ill) hb = 1'b1;
    chk({tag, " ir_write"}, n_ir, 1);
    chk({tag, " reg_write"}, n_rw, v.rw);
    if (v.rw) chk({tag, " dst/mem_to_reg"}, {rd, m2r}, {v.op == OP_RTYPE, v.op == OP_LW});
    chk({tag, " mem_write"}, n_mw, v.op == OP_SW ? v.wd + 1 : 0);
    chk({tag, " data_read"}, n_dr, v.op == OP_LW ? v.wd + 1 : 0);
    chk({tag, " pc_en"}, n_pc, 1 + v.tk);
    if (v.tk) chk({tag, " pc_src"}, psrc, v.op == OP_J ? 2 : 1);
    chk({tag, " illegal"}, n_ill, v.ill);
    if (!v.ill) chk({tag, " alu_op"}, xop, v.aop);
    chk({tag, " ext_zero"}, ez, v.ez);
    chk({tag, " back_to_fetch"}, fsig_a(), FSIG);
    chk({tag, " b_halted"}, {ifb.halted, ifb.mem_read}, hb ? 2 : 1);
  endtask
  logic [5:0] ops[17] = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08,
                          6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h3F, 6'h01};
  logic [5:0] fns[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h3F, 6'h00};
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t tbl[$];
    ifa.opcode = 6'h00;
    ifa.funct = 6'h00;
    ifa.zero = 1'b0;
    ifa.mem_ready = 1'b1;
    #12;
    chk("reset outputs", outs_a(), RST);
    chk("reset b outputs", {ifb.halted, ifb.mem_read, ifb.ir_write, ifb.pc_en}, 4'b0100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifa.mem_ready = 1'b0;
    #1;
    chk("fetch after reset", fsig_a(), FSIG);
    tbl.push_back(mk(6'h00, 6'h20, 0, 0, 0, 4, 2, 0, 0, 1, 0));
    tbl.push_back(mk(6'h23, 6'h00, 0, 0, 2, 7, 2, 0, 0, 1, 0));
    tbl.push_back(mk(6'h04, 6'h00, 1, 0, 0, 3, 3, 0, 1, 0, 0));
    tbl.push_back(mk(6'h04, 6'h00, 0, 0, 0, 3, 3, 0, 0, 0, 0));
    tbl.push_back(mk(6'h05, 6'h00, 0, 0, 0, 3, 3, 0, 1, 0, 0));
    tbl.push_back(mk(6'h0D, 6'h00, 0, 0, 0, 4, 1, 1, 0, 1, 0));
    tbl.push_back(mk(6'h0A, 6'h00, 0, 0, 0, 4, 6, 0, 0, 1, 0));
    tbl.push_back(mk(6'h00, 6'h3F, 0, 0, 0, 4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h2B, 6'h00, 0, 1, 1, 6, 2, 0, 0, 0, 0));
    tbl.push_back(mk(6'h02, 6'h00, 0, 2, 0, 5, 7, 0, 1, 0, 0));
    tbl.push_back(mk(6'h00, 6'h22, 0, 1, 0, 5, 3, 0, 0, 1, 0));
    tbl.push_back(mk(6'h0B, 6'h00, 0, 0, 0, 4, 5, 0, 0, 1, 0));
    tbl.push_back(mk(6'h3F, 6'h00, 0, 0, 0, 3, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6'h0E, 6'h00, 0, 0, 0, 4, 4, 1, 0, 1, 0));
    tbl.push_back(mk(6'h00, 6'h2B, 1, 0, 0, 4, 5, 0, 0, 1, 0));
    foreach (tbl[i]) run(tbl[i], $sformatf("tbl%0d", i));
    chk("halt held", ifb.halted, 1);
    rst_b = 1'b0;
    #1;
    chk("halt cleared by reset", {ifb.halted, ifb.mem_read}, 2'b01);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    hb = 1'b0;
    #1;
    chk("a held in fetch", fsig_a(), FSIG);
    ifa.opcode = OP_SW;
    ifa.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    ifa.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("memwr active", {ifa.mem_write, ifa.iord}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("async reset in memwr", outs_a(), RST);
    ifa.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("reset held", outs_a(), RST);
    rst_n = 1'b1;
    ifa.mem_ready = 1'b0;
    hb = 1'b0;
    #1;
    chk("no write after reset", {ifa.mem_write, ifa.reg_write}, 0);
    chk("restart in fetch", fsig_a(), FSIG);
    @(posedge clk);
    #1;
    chk("still fetch", fsig_a(), FSIG);
    run(model(6'h00, 6'h24, 0, 0, 0), "post_reset_and");
    for (int i = 0; i < 150; i++)
      run(model(ops[$urandom_range(0, 16)], fns[$urandom_range(0, 10)], 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3)), $sformatf("rnd%0d", i));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control unit: the issuing end of the ALU's ALUOp/Zero interface. It sequences fetch, decode, execute, memory and writeback, and drives ALUOp for every ALU use.
- It consumes the ALU's Zero flag to resolve beq/bne.
- It sits beside the datapath (PC, IR, register file, ALU, memory port). It handshakes with instruction/data memory through mem_ready.

Parameters:
- RESET_ON_ILLEGAL, 0: when 1, an illegal opcode/funct parks the FSM in HALT until reset; when 0, the FSM returns to FETCH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU Zero flag, sampled in BRANCH.
- mem_ready  in  1  memory access complete this cycle.
- alu_op  out  3  encoding: 0 and, 1 or, 2 add, 3 sub, 4 xor, 5 sltu, 6 slt.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  0 = B, 1 = constant 4, 2 = imm, 3 = imm<<2.
- ext_zero  out  1  1 = zero-extend imm (andi/ori/xori), 0 = sign-extend.
- pc_src  out  2  0 = ALU out, 1 = ALUOut reg, 2 = jump target.
- pc_en  out  1  PC write enable.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  latch IR.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- halted  out  1  FSM in HALT.

Behaviour:
- Moore FSM, state register reset asynchronously to FETCH.
- All outputs are decoded combinationally from state (plus opcode/funct where noted). Outside the listed assertions they are 0, alu_op = 2 (add).
- With rst_n low: every output is 0, except alu_op = 2 and, because the FSM is held in FETCH, mem_read = 1 (pc_en and ir_write remain 0 since mem_ready is gated by reset).
- FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 1, alu_op = add, pc_src = 0. ir_write and pc_en are asserted only when mem_ready = 1, which also moves the FSM to DECODE; otherwise it stays in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 3, alu_op = add (precompute branch target). Next state:
  - lw/sw -> MEMADR
  - R-type -> RTEXEC
  - beq/bne -> BRANCH
  - addi/addiu/andi/ori/xori/slti/sltiu -> IEXEC
  - j -> JUMP
  - anything else -> ILLEGAL
- MEMADR: alu_src_a = 1, alu_src_b = 2, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1, mem_read = 1. Wait for mem_ready, then MEMWB.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next state FETCH.
- MEMWR: iord = 1, mem_write = 1 held until mem_ready, then FETCH.
- RTEXEC: alu_src_a = 1, alu_src_b = 0. funct mapping: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x2A slt, 0x2B sltu. Any other funct -> ILLEGAL, else -> RWB.
- RWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next state FETCH.
- IEXEC: alu_src_a = 1, alu_src_b = 2. Opcode mapping: addi/addiu add, andi and (ext_zero), ori or (ext_zero), xori xor (ext_zero), slti slt, sltiu sltu. Next state IWB.
- IWB: reg_write = 1, reg_dst = 0. ext_zero is held as in IEXEC. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = sub, pc_src = 1. pc_en = zero for beq, ~zero for bne. Next state FETCH.
- JUMP: pc_src = 2, pc_en = 1. Next state FETCH.
- ILLEGAL: illegal = 1 for exactly one cycle. Next state HALT if RESET_ON_ILLEGAL = 1, else FETCH.
- HALT: halted = 1, all enables 0. Exited only by reset.
- Latency per instruction, counted with zero-wait memory:
  - R-type: 4 cycles
  - I-type ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - j: 3 cycles
  - Each mem_ready-low cycle in FETCH/MEMRD/MEMWR adds one cycle.
- rst_n asserted mid-instruction: immediate return to FETCH. No partial reg_write or mem_write survives past the reset edge.
- mem_ready is ignored in states that issue no memory request.

Decomposition:
- Package mips_ctrl_pkg holds:
  - ALUOp constants (ALU_AND..ALU_SLT, 0..6)
  - opcode and funct constants
  - state enumeration (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, RWB, IEXEC, IWB, BRANCH, JUMP, ILLEGAL, HALT)
  - alu_src_b and pc_src select codes
- One combinational sub-module, alu_op_decode, maps opcode/funct/state to alu_op, ext_zero and a valid flag.

Test Plan:
- Reset, then add (opcode 0, funct 0x20) with mem_ready = 1 -> states FETCH, DECODE, RTEXEC, RWB. alu_op = 2 in RTEXEC; reg_write = 1 and reg_dst = 1 only in RWB; 4 cycles total.
- lw with mem_ready low for 2 cycles in MEMRD -> mem_read and iord held for 3 cycles; reg_write with mem_to_reg = 1 one cycle after mem_ready; 7 cycles total.
- beq with zero = 1 then with zero = 0 -> in BRANCH, alu_op = 3 and pc_src = 1; pc_en = 1 then 0. bne with zero = 0 -> pc_en = 1.
- ori (0x0D) and slti (0x0A) -> IEXEC gives alu_op = 1 with ext_zero = 1, and alu_op = 6 with ext_zero = 0, respectively.
- R-type funct 0x3F with RESET_ON_ILLEGAL = 0 -> illegal pulses one cycle, then FETCH. With RESET_ON_ILLEGAL = 1 -> halted = 1 and it persists until rst_n is pulsed.
- rst_n pulsed low during MEMWR -> outputs drop to reset values asynchronously, no mem_write after release, FSM restarts in FETCH.
